hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage core; producer of forward_a_e/forward_b_e consumed by the E-stage ALU operand muxes.
//  Detects RAW hazards (M/W forwarding), load-use hazards (1-cycle stall), taken branches (flush) and sequences a multi-cycle
//  divide unit in E (freeze F/D/E, bubble into M). Sits beside the datapath; all stall/flush outputs drive pipeline registers.
// PARAMETERS
//  DIV_LATENCY  32  E-stage stall cycles per divide op; must be >= 2
//  REG_AW       5   register-address width
// PORTS
//  clk          in   1       clock; sole clock domain
//  rst          in   1       synchronous, active-high reset
//  rs1_d,rs2_d  in   REG_AW  source regs of instruction in D
//  rs1_e,rs2_e  in   REG_AW  source regs of instruction in E
//  rd_e         in   REG_AW  dest reg of instruction in E
//  load_e       in   1       instruction in E is a load (result from memory)
//  pc_src_e     in   1       branch/jump taken, resolved in E
//  md_start_e   in   1       instruction in E is a divide op
//  rd_m,rd_w    in   REG_AW  dest regs in M / W
//  reg_write_m  in   1       M instruction writes rd_m
//  reg_write_w  in   1       W instruction writes rd_w
//  forward_a_e  out  2       00 reg file, 01 result_w, 10 alu_result_m, 11 reserved (never driven)
//  forward_b_e  out  2       same encoding for operand B
//  stall_f,stall_d,stall_e  out 1  hold PC / D reg / E reg
//  flush_d,flush_e,flush_m  out 1  bubble into D / E / M reg
//  md_done_e    out  1       divide result valid this cycle; E advances at this edge
// BEHAVIOUR
//  Reset: FSM=IDLE, counter=0; while rst high all outputs 0 (forward selects 00).
//  Forwarding (comb, per operand X in {1,2}):
//   - rsX_e!=0 && reg_write_m && rd_m==rsX_e -> 10; else rsX_e!=0 && reg_write_w && rd_w==rsX_e -> 01; else 00.
//   - M beats W when both match. x0 never forwarded. Encoding 11 never produced.
//  Load-use (comb): lw_stall = load_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d) -> stall_f=stall_d=flush_e=1 for exactly one cycle.
//  Branch: pc_src_e -> flush_d=flush_e=1. Branch beats load-use (no stall, both flushes).
//  Divide FSM (IDLE/BUSY/DONE), down-counter width $clog2(DIV_LATENCY):
//   - IDLE & md_start_e -> stall_f/d/e=1, flush_m=1, cnt<=DIV_LATENCY-2, ->BUSY. Divider captures forwarded operands in this cycle.
//   - BUSY: stall_f/d/e=1, flush_m=1; cnt==0 -> DONE else cnt--.
//   - DONE: md_done_e=1, no divide stall, md_start_e ignored; ->IDLE.
//   - Total E freeze = DIV_LATENCY cycles, then 1 DONE cycle; back-to-back divides restart from IDLE the cycle after DONE.
//  Priority: divide stall (IDLE-start or BUSY) masks lw_stall and pc_src_e (E is frozen, so neither is acted on).
//   - In DONE normal rules apply; pc_src_e never coincides with md_start_e (decoder guarantee).
//  Forward selects are driven normally during BUSY but are don't-care (divider already latched its operands).
//  rst mid-divide -> IDLE next edge, all stalls drop; no DONE pulse.
// STRUCTURE
//  hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, FWD_RSVD=2'b11), md_state_t enum (IDLE, BUSY, DONE).
//  One sub-module md_stall_fsm (clk, rst, md_start_e -> md_busy, md_done_e); the rest stays combinational in hazard_unit.
// TESTING
//  1. rd_m=5,reg_write_m=1,rd_w=5,reg_write_w=1,rs1_e=5 -> forward_a_e=10; clear reg_write_m -> 01; rs1_e=0 -> 00.
//  2. load_e=1,rd_e=7,rs2_d=7 -> one cycle stall_f=stall_d=flush_e=1; next cycle (load in M) forward_b_e=10, no stall.
//  3. load-use (rd_e=7,rs1_d=7) plus pc_src_e=1 same cycle -> flush_d=flush_e=1, stall_f=stall_d=0.
//  4. DIV_LATENCY=4, md_start_e held -> stall_e high cycles N..N+3, md_done_e=1 at N+4, stalls low at N+4.
//  5. Two back-to-back divides -> freezes of 4 cycles each, separated by one DONE cycle; exactly 2 md_done_e pulses.
//  6. rst asserted at BUSY cnt=1 -> next cycle all outputs 0, FSM IDLE; md_done_e never pulses.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encoding and divide FSM states.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF   = 2'b00,
      FWD_W    = 2'b01,
      FWD_M    = 2'b10,
      FWD_RSVD = 2'b11
   } fwd_sel_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } md_state_t;

endpackage

// File: rtl/md_stall_fsm.sv
// Sequences the multi-cycle divider in E: freezes the front of the pipe for DIV_LATENCY cycles,
// then raises md_done_e for one cycle while E advances.
module md_stall_fsm
   import hazard_pkg::*;
#(
   parameter int DIV_LATENCY = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic md_start_e,
   output logic md_busy,
   output logic md_done_e
);

   localparam int CNT_W = $clog2(DIV_LATENCY);

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The start cycle is itself a freeze cycle, so BUSY only covers DIV_LATENCY-1 more.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      md_busy   = 1'b0;
      md_done_e = 1'b0;
      case (state_q)
         IDLE: begin
            if (md_start_e) begin
               md_busy = 1'b1;
               cnt_d   = CNT_W'(DIV_LATENCY - 2);
               state_d = BUSY;
            end
         end
         BUSY: begin
            md_busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            md_done_e = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (rst) begin
         md_busy   = 1'b0;
         md_done_e = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: M/W operand forwarding, load-use stall, branch flush and
// divide freeze for the 5-stage core.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int DIV_LATENCY = 32,
   parameter int REG_AW      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              load_e,
   input  logic              pc_src_e,
   input  logic              md_start_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m,
   output logic              md_done_e
);

   logic     md_busy;
   logic     lw_stall;
   fwd_sel_t fwd_a, fwd_b;

   md_stall_fsm #(
      .DIV_LATENCY (DIV_LATENCY)
   ) u_md_fsm (
      .clk        (clk),
      .rst        (rst),
      .md_start_e (md_start_e),
      .md_busy    (md_busy),
      .md_done_e  (md_done_e)
   );

   // Youngest producer (M) wins; x0 is hard-wired zero and is never forwarded.
   function automatic fwd_sel_t pick_fwd(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] dm,
      input logic              wm,
      input logic [REG_AW-1:0] dw,
      input logic              ww
   );
      fwd_sel_t sel;
      sel = FWD_RF;
      if (rs != '0) begin
         if (wm && (dm == rs)) begin
            sel = FWD_M;
         end else if (ww && (dw == rs)) begin
            sel = FWD_W;
         end
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a = pick_fwd(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      fwd_b = pick_fwd(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
   end

   assign lw_stall = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

   // While the divider holds E, neither a branch nor a load-use in E is real yet.
   always_comb begin
      forward_a_e = FWD_RF;
      forward_b_e = FWD_RF;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      flush_m     = 1'b0;
      if (!rst) begin
         forward_a_e = fwd_a;
         forward_b_e = fwd_b;
         if (md_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
         end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: table of combinational vectors plus hand-written divide/reset sequences.
module tb_hazard_unit;
   import hazard_pkg::*;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic          load_e, pc_src_e, md_start_e, reg_write_m, reg_write_w;
   logic [1:0]    forward_a_e, forward_b_e;
   logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_done_e;

   int n_vec  = 0;
   int n_miss = 0;

   hazard_unit #(
      .DIV_LATENCY (4),
      .REG_AW      (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rs1_d       (rs1_d),
      .rs2_d       (rs2_d),
      .rs1_e       (rs1_e),
      .rs2_e       (rs2_e),
      .rd_e        (rd_e),
      .load_e      (load_e),
      .pc_src_e    (pc_src_e),
      .md_start_e  (md_start_e),
      .rd_m        (rd_m),
      .rd_w        (rd_w),
      .reg_write_m (reg_write_m),
      .reg_write_w (reg_write_w),
      .forward_a_e (forward_a_e),
      .forward_b_e (forward_b_e),
      .stall_f     (stall_f),
      .stall_d     (stall_d),
      .stall_e     (stall_e),
      .flush_d     (flush_d),
      .flush_e     (flush_e),
      .flush_m     (flush_m),
      .md_done_e   (md_done_e)
   );

   always #5 clk = ~clk;

   // Output bundle: {fwd_a[1:0], fwd_b[1:0], stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_done}
   function automatic logic [10:0] outs();
      return {forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
              flush_d, flush_e, flush_m, md_done_e};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b", name, act[10:0], exp[10:0]);
      end
   endtask

   task automatic clear_inputs();
      rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
      load_e = 1'b0; pc_src_e = 1'b0; md_start_e = 1'b0;
      reg_write_m = 1'b0; reg_write_w = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string         name;
      logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
      logic          load_e, pc_src_e;
      logic [AW-1:0] rd_m;
      logic          rw_m;
      logic [AW-1:0] rd_w;
      logic          rw_w;
      logic [10:0]   exp;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int done_cnt;

      //                 name             rs1d rs2d rs1e rs2e rde ld pc rdm wm rdw ww  expected
      vecs[0]  = '{"fwd_m_beats_w",   0, 0, 5, 0, 0, 0, 0, 5, 1, 5, 1, 11'b10_00_000_000_0};
      vecs[1]  = '{"fwd_w",           0, 0, 5, 0, 0, 0, 0, 5, 0, 5, 1, 11'b01_00_000_000_0};
      vecs[2]  = '{"fwd_rs_x0",       0, 0, 0, 0, 0, 0, 0, 5, 1, 5, 1, 11'b00_00_000_000_0};
      vecs[3]  = '{"fwd_a_m_b_w",     0, 0, 4, 3, 0, 0, 0, 4, 1, 3, 1, 11'b10_01_000_000_0};
      vecs[4]  = '{"fwd_both_m",      0, 0, 9, 9, 0, 0, 0, 9, 1, 9, 1, 11'b10_10_000_000_0};
      vecs[5]  = '{"fwd_rd_x0",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 11'b00_00_000_000_0};
      vecs[6]  = '{"fwd_no_write",    0, 0, 0, 6, 0, 0, 0, 6, 0, 6, 0, 11'b00_00_000_000_0};
      vecs[7]  = '{"lw_stall_rs2",    0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 11'b00_00_110_010_0};
      vecs[8]  = '{"lw_then_fwd_m",   0, 0, 0, 7, 0, 0, 0, 7, 1, 0, 0, 11'b00_10_000_000_0};
      vecs[9]  = '{"lw_plus_branch",  7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 11'b00_00_000_110_0};
      vecs[10] = '{"lw_rd_x0",        0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 11'b00_00_000_000_0};
      vecs[11] = '{"no_load_match",   7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 11'b00_00_000_000_0};
      vecs[12] = '{"branch_only",     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 11'b00_00_000_110_0};
      vecs[13] = '{"lw_no_match",     3, 4, 0, 0, 7, 1, 0, 0, 0, 0, 0, 11'b00_00_000_000_0};
      vecs[14] = '{"lw_rs1_with_fwd", 8, 0, 2, 0, 8, 1, 0, 0, 0, 2, 1, 11'b01_00_110_010_0};

      // Reset: everything active on the inputs, outputs must stay quiet
      clear_inputs();
      rst = 1'b1;
      rs1_e = 5; rd_m = 5; reg_write_m = 1'b1; md_start_e = 1'b1; pc_src_e = 1'b1;
      load_e = 1'b1; rd_e = 3; rs1_d = 3;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("reset_outputs", 32'(outs()), 32'(11'b0));
      check("reset_state", 32'(dut.u_md_fsm.state_q), 32'(IDLE));

      next_cycle();
      rst = 1'b0;
      clear_inputs();

      for (int i = 0; i < 15; i++) begin
         next_cycle();
         rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
         rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e;
         rd_e = vecs[i].rd_e; load_e = vecs[i].load_e; pc_src_e = vecs[i].pc_src_e;
         rd_m = vecs[i].rd_m; reg_write_m = vecs[i].rw_m;
         rd_w = vecs[i].rd_w; reg_write_w = vecs[i].rw_w;
         @(negedge clk);
         check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      end

      // Single divide, DIV_LATENCY=4: freeze N..N+3, done at N+4
      next_cycle();
      clear_inputs();
      md_start_e = 1'b1;
      @(negedge clk);
      check("div_start_freeze", 32'(outs()), 32'(11'b00_00_111_001_0));
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         if (k == 2) begin
            load_e = 1'b1; rd_e = 7; rs1_d = 7;
         end else begin
            load_e = 1'b0; rd_e = 0; rs1_d = 0;
         end
         @(negedge clk);
         check($sformatf("div_busy_%0d", k), 32'(outs()), 32'(11'b00_00_111_001_0));
      end
      next_cycle();
      load_e = 1'b0; rd_e = 0; rs1_d = 0;
      @(negedge clk);
      check("div_done", 32'(outs()), 32'(11'b00_00_000_000_1));
      next_cycle();
      md_start_e = 1'b0;
      @(negedge clk);
      check("div_after_done", 32'(outs()), 32'(11'b0));
      check("div_after_state", 32'(dut.u_md_fsm.state_q), 32'(IDLE));

      // Back-to-back divides with md_start_e held throughout
      done_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         next_cycle();
         md_start_e = 1'b1;
         @(negedge clk);
         done_cnt += int'(md_done_e);
         if ((k % 5) == 4)
            check($sformatf("b2b_done_%0d", k), 32'(outs()), 32'(11'b00_00_000_000_1));
         else
            check($sformatf("b2b_freeze_%0d", k), 32'(outs()), 32'(11'b00_00_111_001_0));
      end
      next_cycle();
      md_start_e = 1'b0;
      @(negedge clk);
      done_cnt += int'(md_done_e);
      check("b2b_done_pulses", 32'(done_cnt), 32'd2);

      // Reset at BUSY cnt=1: freeze drops, no done pulse afterwards
      next_cycle();
      md_start_e = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("rst_mid_busy_pre", 32'(outs()), 32'(11'b00_00_111_001_0));
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_gated", 32'(outs()), 32'(11'b0));
      next_cycle();
      rst = 1'b0;
      md_start_e = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs", 32'(outs()), 32'(11'b0));
      check("rst_mid_state", 32'(dut.u_md_fsm.state_q), 32'(IDLE));
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         @(negedge clk);
         check($sformatf("rst_no_done_%0d", k), 32'(md_done_e), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
